// File: rtl/rr_merge3_arbiter.sv
// rr_merge3_arbiter
// Merges three first-word-fall-through source FIFOs (a = routing, b = east,
// c = west) onto one downstream write port. Each cycle at most one source is
// popped, chosen round-robin starting after the most recently granted source.
// The popped head word is registered and presented one cycle later together
// with a single-cycle write strobe and the id of the source it came from.
// Packet contents pass through unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din_a/b/c  head word of each source FIFO (DATA_WIDTH)
//   empty_a/b/c source FIFO empty flags
//   out_full   downstream cannot accept a write on the next cycle
//   ren_a/b/c  combinational pop strobes, at most one high per cycle
//   dout       registered forwarded packet
//   wen        registered write strobe qualifying dout
//   grant_id   registered source of dout: 0=a, 1=b, 2=c
//   pkt_count  registered count of forwarded packets, wraps to zero
module rr_merge3_arbiter #(
  parameter int DATA_WIDTH = 21,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic [DATA_WIDTH-1:0] din_c,
  input  logic                  empty_a,
  input  logic                  empty_b,
  input  logic                  empty_c,
  input  logic                  out_full,
  output logic                  ren_a,
  output logic                  ren_b,
  output logic                  ren_c,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  wen,
  output logic [1:0]            grant_id,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_e;

  src_e                  lastGrant_q, lastGrant_d;
  src_e                  grantId_q, grantId_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wen_q, wen_d;
  logic [CNT_WIDTH-1:0]  pktCount_q, pktCount_d;

  logic [2:0]            eligible;
  logic                  grantValid;
  src_e                  grantSrc;
  logic [DATA_WIDTH-1:0] grantData;

  // Eligibility is purely combinational so an empty flag or out_full rising
  // this cycle suppresses the pop immediately. Gating with rst keeps every
  // pop strobe low while reset is held, even though the FIFOs may hold data.
  assign eligible = {~empty_c, ~empty_b, ~empty_a} & {3{~out_full & ~rst}};

  // Round-robin pick: the search starts at the source following the last
  // grant and wraps a->b->c->a, so each priority order is spelled out per
  // last-grant value. The encoding 3 is unreachable and is folded into the
  // "last was c" case.
  always_comb begin
    grantValid = 1'b0;
    grantSrc   = SRC_A;
    unique case (lastGrant_q)
      SRC_A: begin
        if (eligible[1])      begin grantValid = 1'b1; grantSrc = SRC_B; end
        else if (eligible[2]) begin grantValid = 1'b1; grantSrc = SRC_C; end
        else if (eligible[0]) begin grantValid = 1'b1; grantSrc = SRC_A; end
      end
      SRC_B: begin
        if (eligible[2])      begin grantValid = 1'b1; grantSrc = SRC_C; end
        else if (eligible[0]) begin grantValid = 1'b1; grantSrc = SRC_A; end
        else if (eligible[1]) begin grantValid = 1'b1; grantSrc = SRC_B; end
      end
      default: begin
        if (eligible[0])      begin grantValid = 1'b1; grantSrc = SRC_A; end
        else if (eligible[1]) begin grantValid = 1'b1; grantSrc = SRC_B; end
        else if (eligible[2]) begin grantValid = 1'b1; grantSrc = SRC_C; end
      end
    endcase
  end

  // Select the head word of the granted source for capture into dout.
  always_comb begin
    grantData = din_a;
    unique case (grantSrc)
      SRC_B:   grantData = din_b;
      SRC_C:   grantData = din_c;
      default: grantData = din_a;
    endcase
  end

  assign ren_a = grantValid && (grantSrc == SRC_A);
  assign ren_b = grantValid && (grantSrc == SRC_B);
  assign ren_c = grantValid && (grantSrc == SRC_C);

  // Next-state: a grant captures data/id and raises wen for exactly one
  // cycle; without a grant dout, grant_id and the round-robin pointer hold.
  // The counter advances on the same edge that raises wen, so it already
  // includes the packet currently being presented.
  always_comb begin
    lastGrant_d = lastGrant_q;
    grantId_d   = grantId_q;
    dout_d      = dout_q;
    wen_d       = 1'b0;
    pktCount_d  = pktCount_q;
    if (grantValid) begin
      lastGrant_d = grantSrc;
      grantId_d   = grantSrc;
      dout_d      = grantData;
      wen_d       = 1'b1;
      pktCount_d  = pktCount_q + CNT_WIDTH'(1);
    end
  end

  // Output and pointer registers. The pointer resets to c so that source a
  // is searched first once reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant_q <= SRC_C;
      grantId_q   <= SRC_A;
      dout_q      <= '0;
      wen_q       <= 1'b0;
      pktCount_q  <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      dout_q      <= dout_d;
      wen_q       <= wen_d;
      pktCount_q  <= pktCount_d;
    end
  end

  assign dout      = dout_q;
  assign wen       = wen_q;
  assign grant_id  = grantId_q;
  assign pkt_count = pktCount_q;

endmodule

// File: tb/tb_rr_merge3_arbiter.sv
// tb_rr_merge3_arbiter
// Directed bench for rr_merge3_arbiter. A small round-robin model predicts
// the pop strobe each cycle; every predicted grant pushes the expected
// {data, id} onto a scoreboard which is popped when the registered output
// should appear one cycle later. The counter is built 4 bits wide so the
// wrap from all-ones to zero is reached quickly.
module tb_rr_merge3_arbiter;

  localparam int DW = 21;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din_a, din_b, din_c;
  logic          empty_a, empty_b, empty_c;
  logic          out_full;
  logic          ren_a, ren_b, ren_c;
  logic [DW-1:0] dout;
  logic          wen;
  logic [1:0]    grant_id;
  logic [CW-1:0] pkt_count;

  rr_merge3_arbiter #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_a    (din_a),
    .din_b    (din_b),
    .din_c    (din_c),
    .empty_a  (empty_a),
    .empty_b  (empty_b),
    .empty_c  (empty_c),
    .out_full (out_full),
    .ren_a    (ren_a),
    .ren_b    (ren_b),
    .ren_c    (ren_c),
    .dout     (dout),
    .wen      (wen),
    .grant_id (grant_id),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model state
  exp_t          sbQueue[$];
  int            modelLast;
  logic [DW-1:0] expDout;
  logic [1:0]    expId;
  logic [CW-1:0] expCount;
  int            vecCount = 0;
  int            errCount = 0;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkEq(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  // Clear the reference model to the post-reset state.
  task automatic modelReset();
    sbQueue.delete();
    modelLast = 2;
    expDout   = '0;
    expId     = 2'd0;
    expCount  = '0;
  endtask

  // Predicted one-hot {c,b,a} pop for the given empty vector {c,b,a}.
  function automatic logic [2:0] predictRen(input logic [2:0] emptyV,
                                            input logic full, input logic inReset);
    logic [2:0] elig;
    int idx;
    elig = (full || inReset) ? 3'b000 : ~emptyV;
    for (int i = 1; i <= 3; i++) begin
      idx = (modelLast + i) % 3;
      if (elig[idx]) return 3'b001 << idx;
    end
    return 3'b000;
  endfunction

  // After an active edge: the scoreboard decides whether a packet is due.
  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      expDout  = e.data;
      expId    = e.id;
      expCount = expCount + 1'b1;
      checkEq("wen", 32'(wen), 32'd1);
    end else begin
      checkEq("wen", 32'(wen), 32'd0);
    end
    checkEq("dout", 32'(dout), 32'(expDout));
    checkEq("grant_id", 32'(grant_id), 32'(expId));
    checkEq("pkt_count", 32'(pkt_count), 32'(expCount));
  endtask

  // One cycle: drive sources, check the pop strobe, clock, check outputs.
  task automatic applyStimulus(input logic [2:0] emptyV, input logic full,
                               input logic [DW-1:0] da, input logic [DW-1:0] db,
                               input logic [DW-1:0] dc);
    logic [2:0] expRen;
    exp_t e;
    {empty_c, empty_b, empty_a} = emptyV;
    out_full = full;
    din_a = da;
    din_b = db;
    din_c = dc;
    #1;
    expRen = predictRen(emptyV, full, rst);
    checkEq("ren", 32'({ren_c, ren_b, ren_a}), 32'(expRen));
    if (expRen != 3'b000) begin
      unique case (expRen)
        3'b001:  begin e.data = da; e.id = 2'd0; modelLast = 0; end
        3'b010:  begin e.data = db; e.id = 2'd1; modelLast = 1; end
        default: begin e.data = dc; e.id = 2'd2; modelLast = 2; end
      endcase
      sbQueue.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkResetState(input string tag);
    checkEq({tag, "_ren"}, 32'({ren_c, ren_b, ren_a}), 32'd0);
    checkEq({tag, "_wen"}, 32'(wen), 32'd0);
    checkEq({tag, "_dout"}, 32'(dout), 32'd0);
    checkEq({tag, "_gid"}, 32'(grant_id), 32'd0);
    checkEq({tag, "_cnt"}, 32'(pkt_count), 32'd0);
  endtask

  initial begin
    // Reset held with every source non-empty: nothing may be popped.
    rst = 1'b1;
    {empty_c, empty_b, empty_a} = 3'b000;
    out_full = 1'b0;
    din_a = rnd(); din_b = rnd(); din_c = rnd();
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");

    // Release between edges; the very next cycle must grant a.
    rst = 1'b0;
    #1;
    checkEq("first_ren_a", 32'(ren_a), 32'd1);

    // All sources eligible for 9 cycles: a,b,c repeating, no bubbles.
    for (int i = 0; i < 9; i++)
      applyStimulus(3'b000, 1'b0, rnd(), rnd(), rnd());
    checkEq("count_after_9", 32'(pkt_count), 32'd9);

    // Only b non-empty with a fixed head word.
    for (int i = 0; i < 4; i++)
      applyStimulus(3'b101, 1'b0, rnd(), 21'h00ABC, rnd());
    checkEq("b_only_dout", 32'(dout), 32'h00ABC);

    // a and c non-empty, then a 3-cycle stall, then resume.
    applyStimulus(3'b010, 1'b0, rnd(), rnd(), rnd());
    for (int i = 0; i < 3; i++)
      applyStimulus(3'b010, 1'b1, rnd(), rnd(), rnd());
    for (int i = 0; i < 3; i++)
      applyStimulus(3'b010, 1'b0, rnd(), rnd(), rnd());

    // a's empty flag rises exactly when it would be next in line.
    while (modelLast != 2)
      applyStimulus(3'b000, 1'b0, rnd(), rnd(), rnd());
    applyStimulus(3'b001, 1'b0, rnd(), rnd(), rnd());

    // Idle cycle: wen drops, dout/grant_id hold.
    applyStimulus(3'b111, 1'b0, rnd(), rnd(), rnd());

    // Asynchronous reset mid-cycle right after a grant was registered.
    applyStimulus(3'b000, 1'b0, rnd(), rnd(), rnd());
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkResetState("async_rst");
    #2;
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0, rnd(), rnd(), rnd());
    checkEq("post_rst_gid_a", 32'(grant_id), 32'd0);

    // Counter wrap: bring it to all-ones, then one more grant.
    while (expCount != 4'hF)
      applyStimulus(3'b110, 1'b0, rnd(), rnd(), rnd());
    checkEq("cnt_all_ones", 32'(pkt_count), 32'hF);
    applyStimulus(3'b110, 1'b0, rnd(), rnd(), rnd());
    checkEq("cnt_wrap", 32'(pkt_count), 32'd0);
    applyStimulus(3'b111, 1'b0, rnd(), rnd(), rnd());

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
